// File: rtl/crack_pkg.sv
`default_nettype none
// ============================================================================
//  crack_pkg
//  Shared types and defaults for the crack_search key-sweep block.
//  Revision: 1.0 - initial release
// ============================================================================
package crack_pkg;

   // Default key width and printable-character window
   localparam int         KEY_W_DEF   = 24;
   localparam logic [7:0] CHAR_LO_DEF = 8'h20;
   localparam logic [7:0] CHAR_HI_DEF = 8'h7E;

   // Search controller states
   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_LEN_RD  = 4'd1,
      ST_LEN_LAT = 4'd2,
      ST_START   = 4'd3,
      ST_RUN     = 4'd4,
      ST_CHK_RD  = 4'd5,
      ST_CHK     = 4'd6,
      ST_NEXT    = 4'd7,
      ST_DRAIN   = 4'd8
   } crack_state_t;

endpackage : crack_pkg
`default_nettype wire

// File: rtl/char_check.sv
`default_nettype none
// ============================================================================
//  char_check
//  Combinational test that a plaintext byte lies in [CHAR_LO, CHAR_HI].
//  Revision: 1.0 - initial release
// ============================================================================
module char_check
   import crack_pkg::*;
#(
   parameter logic [7:0] CHAR_LO = CHAR_LO_DEF,
   parameter logic [7:0] CHAR_HI = CHAR_HI_DEF
) (
   input  logic [7:0] ch,
   output logic       ok
);

   // Inclusive window compare on both ends
   assign ok = (ch >= CHAR_LO) && (ch <= CHAR_HI);

endmodule : char_check
`default_nettype wire

// File: rtl/crack_search.sv
`default_nettype none
// ============================================================================
//  crack_search
//  Sweeps candidate keys from key_start to key_limit in steps of KEY_STRIDE,
//  runs an external arc4 core on each and accepts the first key whose
//  plaintext is entirely inside the printable window.
//  Optional build macro: CRACK_SEARCH_STATS_EN (keys_tried counter).
//  Revision: 1.0 - initial release
// ============================================================================
module crack_search
   import crack_pkg::*;
#(
   parameter int         KEY_W      = KEY_W_DEF,
   parameter int         KEY_STRIDE = 1,
   parameter logic [7:0] CHAR_LO    = CHAR_LO_DEF,
   parameter logic [7:0] CHAR_HI    = CHAR_HI_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic             rdy,
   input  logic             stop,
   input  logic [KEY_W-1:0] key_start,
   input  logic [KEY_W-1:0] key_limit,
   output logic [KEY_W-1:0] key,
   output logic             key_valid,
   output logic             exhausted,
   output logic [7:0]       ct_addr,
   input  logic [7:0]       ct_rddata,
   output logic [7:0]       pt_addr,
   input  logic [7:0]       pt_rddata,
   output logic             arc4_en,
   input  logic             arc4_rdy,
   output logic [KEY_W-1:0] arc4_key,
   output logic             arc4_busy,
   output logic [KEY_W-1:0] keys_tried
);

   localparam logic [KEY_W:0] c_stride = (KEY_W+1)'(KEY_STRIDE);

   crack_state_t     r_state;
   logic [KEY_W-1:0] r_key;
   logic             r_key_valid;
   logic             r_exhausted;
   logic             r_rdy;
   logic             r_arc4_en;
   logic             r_arc4_busy;
   logic             r_arc4_rdy_q;
   logic [7:0]       r_pt_addr;
   logic [7:0]       r_msg_len;
   logic [8:0]       r_idx;

   logic             w_byte_ok;
   logic             w_rdy_rise;
   logic [KEY_W:0]   w_key_next;
   logic             w_last_key;
   logic [8:0]       w_idx_inc;
   logic             w_past_end;
   logic             w_inc_in_msg;

   char_check #(
      .CHAR_LO (CHAR_LO),
      .CHAR_HI (CHAR_HI)
   ) u_char_check (
      .ch (pt_rddata),
      .ok (w_byte_ok)
   );

   // arc4 completion is a 0->1 transition; rdy is still high during the
   // first RUN cycle because the core has not yet seen arc4_en.
   assign w_rdy_rise   = arc4_rdy & ~r_arc4_rdy_q;
   // One extra bit catches carry-out; since key_limit's top bit is zero, an
   // overflowing successor always compares above the limit.
   assign w_key_next   = {1'b0, r_key} + c_stride;
   assign w_last_key   = w_key_next > {1'b0, key_limit};
   assign w_idx_inc    = r_idx + 9'd1;
   assign w_past_end   = r_idx > {1'b0, r_msg_len};
   assign w_inc_in_msg = w_idx_inc <= {1'b0, r_msg_len};

   // Search controller with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_key        <= '0;
         r_key_valid  <= 1'b0;
         r_exhausted  <= 1'b0;
         r_rdy        <= 1'b1;
         r_arc4_en    <= 1'b0;
         r_arc4_busy  <= 1'b0;
         r_arc4_rdy_q <= 1'b0;
         r_pt_addr    <= 8'h00;
         r_msg_len    <= 8'h00;
         r_idx        <= 9'd0;
      end else begin
         r_arc4_rdy_q <= arc4_rdy;
         r_arc4_en    <= 1'b0;
         if (stop && (r_state != ST_IDLE) && (r_state != ST_DRAIN)) begin
            r_pt_addr <= 8'h00;
            if ((r_state == ST_RUN) && !w_rdy_rise) begin
               // arc4 still owns the memories; let it finish first
               r_state <= ST_DRAIN;
            end else begin
               r_state     <= ST_IDLE;
               r_rdy       <= 1'b1;
               r_arc4_busy <= 1'b0;
            end
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (en) begin
                     r_key       <= key_start;
                     r_key_valid <= 1'b0;
                     r_exhausted <= 1'b0;
                     r_rdy       <= 1'b0;
                     r_state     <= ST_LEN_RD;
                  end
               end
               ST_LEN_RD: r_state <= ST_LEN_LAT;
               ST_LEN_LAT: begin
                  r_msg_len <= ct_rddata;
                  r_state   <= ST_START;
               end
               ST_START: begin
                  if (arc4_rdy) begin
                     r_arc4_en   <= 1'b1;
                     r_arc4_busy <= 1'b1;
                     r_state     <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  if (w_rdy_rise) begin
                     r_idx       <= 9'd1;
                     r_pt_addr   <= (r_msg_len != 8'h00) ? 8'h01 : 8'h00;
                     r_arc4_busy <= 1'b0;
                     r_state     <= ST_CHK_RD;
                  end
               end
               ST_CHK_RD: begin
                  if (w_past_end) begin
                     r_key_valid <= 1'b1;
                     r_rdy       <= 1'b1;
                     r_state     <= ST_IDLE;
                  end else begin
                     r_state <= ST_CHK;
                  end
               end
               ST_CHK: begin
                  if (!w_byte_ok) begin
                     r_pt_addr <= 8'h00;
                     r_state   <= ST_NEXT;
                  end else begin
                     r_idx     <= w_idx_inc;
                     r_pt_addr <= w_inc_in_msg ? w_idx_inc[7:0] : 8'h00;
                     r_state   <= ST_CHK_RD;
                  end
               end
               ST_NEXT: begin
                  if (w_last_key) begin
                     r_exhausted <= 1'b1;
                     r_rdy       <= 1'b1;
                     r_state     <= ST_IDLE;
                  end else begin
                     r_key   <= w_key_next[KEY_W-1:0];
                     r_state <= ST_START;
                  end
               end
               ST_DRAIN: begin
                  if (w_rdy_rise) begin
                     r_arc4_busy <= 1'b0;
                     r_rdy       <= 1'b1;
                     r_state     <= ST_IDLE;
                  end
               end
               default: begin
                  r_rdy   <= 1'b1;
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

`ifdef CRACK_SEARCH_STATS_EN
   logic [KEY_W-1:0] r_keys_tried;

   // Saturating count of NEXT entries (every rejected key)
   always_ff @(posedge clk) begin
      if (rst) begin
         r_keys_tried <= '0;
      end else if ((r_state == ST_IDLE) && en && !stop) begin
         r_keys_tried <= '0;
      end else if ((r_state == ST_CHK) && !w_byte_ok && !stop) begin
         if (r_keys_tried != {KEY_W{1'b1}}) begin
            r_keys_tried <= r_keys_tried + 1'b1;
         end
      end
   end

   assign keys_tried = r_keys_tried;
`else
   assign keys_tried = '0;
`endif

   // Only the length byte at CT address 0 is read by this block
   assign ct_addr   = 8'h00;
   assign pt_addr   = r_pt_addr;
   assign rdy       = r_rdy;
   assign key       = r_key;
   assign key_valid = r_key_valid;
   assign exhausted = r_exhausted;
   assign arc4_en   = r_arc4_en;
   assign arc4_busy = r_arc4_busy;
   assign arc4_key  = r_key;

endmodule : crack_search
`default_nettype wire

// File: tb/tb_crack_search.sv
`default_nettype none
// ============================================================================
//  tb_crack_search
//  Scoreboard bench: two crack_search instances (24-bit/stride 1 and
//  8-bit/stride 4) with behavioural arc4 cores and CT/PT memories.
//  The toy cipher XORs every byte with the bit-reversed low key byte.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_crack_search;

   localparam int LAT = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        en_a = 1'b0, stop_a = 1'b0;
   logic        rdy_a, key_valid_a, exhausted_a, arc4_en_a, arc4_busy_a;
   logic        arc4_rdy_a;
   logic [23:0] key_start_a = '0, key_limit_a = '0;
   logic [23:0] key_a, arc4_key_a, keys_tried_a;
   logic [7:0]  ct_addr_a, ct_rd_a, pt_addr_a, pt_rd_a;

   logic        en_b = 1'b0, stop_b = 1'b0;
   logic        rdy_b, key_valid_b, exhausted_b, arc4_en_b, arc4_busy_b;
   logic        arc4_rdy_b;
   logic [7:0]  key_start_b = '0, key_limit_b = '0;
   logic [7:0]  key_b, arc4_key_b, keys_tried_b;
   logic [7:0]  ct_addr_b, ct_rd_b, pt_addr_b, pt_rd_b;

   logic [7:0]  ct_mem   [256];
   logic [7:0]  pt_mem_a [256];
   logic [7:0]  pt_mem_b [256];

   crack_search #(.KEY_W(24), .KEY_STRIDE(1)) u_dut_a (
      .clk(clk), .rst(rst), .en(en_a), .rdy(rdy_a), .stop(stop_a),
      .key_start(key_start_a), .key_limit(key_limit_a), .key(key_a),
      .key_valid(key_valid_a), .exhausted(exhausted_a),
      .ct_addr(ct_addr_a), .ct_rddata(ct_rd_a),
      .pt_addr(pt_addr_a), .pt_rddata(pt_rd_a),
      .arc4_en(arc4_en_a), .arc4_rdy(arc4_rdy_a), .arc4_key(arc4_key_a),
      .arc4_busy(arc4_busy_a), .keys_tried(keys_tried_a)
   );

   crack_search #(.KEY_W(8), .KEY_STRIDE(4)) u_dut_b (
      .clk(clk), .rst(rst), .en(en_b), .rdy(rdy_b), .stop(stop_b),
      .key_start(key_start_b), .key_limit(key_limit_b), .key(key_b),
      .key_valid(key_valid_b), .exhausted(exhausted_b),
      .ct_addr(ct_addr_b), .ct_rddata(ct_rd_b),
      .pt_addr(pt_addr_b), .pt_rddata(pt_rd_b),
      .arc4_en(arc4_en_b), .arc4_rdy(arc4_rdy_b), .arc4_key(arc4_key_b),
      .arc4_busy(arc4_busy_b), .keys_tried(keys_tried_b)
   );

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   // Synchronous 1-cycle-latency memory read ports
   always @(posedge clk) begin
      ct_rd_a <= ct_mem[ct_addr_a];
      ct_rd_b <= ct_mem[ct_addr_b];
      pt_rd_a <= pt_mem_a[pt_addr_a];
      pt_rd_b <= pt_mem_b[pt_addr_b];
   end

   // Behavioural arc4 cores: accept en while rdy, busy LAT+1 cycles
   int         cnt_a, cnt_b;
   logic [7:0] ks_a, ks_b;
   always @(posedge clk) begin
      if (rst) begin
         arc4_rdy_a <= 1'b1; cnt_a <= 0;
      end else if (arc4_rdy_a && arc4_en_a) begin
         arc4_rdy_a <= 1'b0; cnt_a <= LAT; ks_a <= rev8(arc4_key_a[7:0]);
      end else if (!arc4_rdy_a) begin
         if (cnt_a == 0) begin
            for (int i = 0; i < 256; i++) pt_mem_a[i] <= ct_mem[i] ^ ks_a;
            arc4_rdy_a <= 1'b1;
         end else cnt_a <= cnt_a - 1;
      end
   end
   always @(posedge clk) begin
      if (rst) begin
         arc4_rdy_b <= 1'b1; cnt_b <= 0;
      end else if (arc4_rdy_b && arc4_en_b) begin
         arc4_rdy_b <= 1'b0; cnt_b <= LAT; ks_b <= rev8(arc4_key_b);
      end else if (!arc4_rdy_b) begin
         if (cnt_b == 0) begin
            for (int i = 0; i < 256; i++) pt_mem_b[i] <= ct_mem[i] ^ ks_b;
            arc4_rdy_b <= 1'b1;
         end else cnt_b <= cnt_b - 1;
      end
   end

   typedef struct packed {
      logic [23:0] key;
      logic        valid;
      logic        exh;
      logic [23:0] tried;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e_mon;
   int   checks = 0;
   int   errors = 0;

   function automatic logic [23:0] exp_tried(input int n);
`ifdef CRACK_SEARCH_STATS_EN
      return 24'(n);
`else
      return 24'(n * 0);
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every rdy rising edge is a completed search to score
   logic mon_en = 1'b0;
   logic prev_rdy_a = 1'b1, prev_rdy_b = 1'b1;
   int   pt_nz_cnt = 0;
   always @(negedge clk) begin
      if (pt_addr_a != 8'h00) pt_nz_cnt++;
      if (mon_en) begin
         if (rdy_a && !prev_rdy_a) begin
            if (q_a.size() == 0) chk("a_unexpected_done", 32'd1, 32'd0);
            else begin
               e_mon = q_a.pop_front();
               chk("a_key",        32'(key_a),        32'(e_mon.key));
               chk("a_key_valid",  32'(key_valid_a),  32'(e_mon.valid));
               chk("a_exhausted",  32'(exhausted_a),  32'(e_mon.exh));
               chk("a_keys_tried", 32'(keys_tried_a), 32'(e_mon.tried));
            end
         end
         if (rdy_b && !prev_rdy_b) begin
            if (q_b.size() == 0) chk("b_unexpected_done", 32'd1, 32'd0);
            else begin
               e_mon = q_b.pop_front();
               chk("b_key",        32'(key_b),        32'(e_mon.key));
               chk("b_key_valid",  32'(key_valid_b),  32'(e_mon.valid));
               chk("b_exhausted",  32'(exhausted_b),  32'(e_mon.exh));
               chk("b_keys_tried", 32'(keys_tried_b), 32'(e_mon.tried));
            end
         end
      end
      prev_rdy_a = rdy_a;
      prev_rdy_b = rdy_b;
   end

   task automatic start_a(input logic [23:0] ks, input logic [23:0] kl);
      @(posedge clk); #1;
      key_start_a = ks; key_limit_a = kl; en_a = 1'b1;
      @(posedge clk); #1;
      en_a = 1'b0;
   endtask

   task automatic start_b(input logic [7:0] ks, input logic [7:0] kl);
      @(posedge clk); #1;
      key_start_b = ks; key_limit_b = kl; en_b = 1'b1;
      @(posedge clk); #1;
      en_b = 1'b0;
   endtask

   task automatic wait_done_a(input int budget);
      int n = 0;
      while (q_a.size() != 0 && n < budget) begin @(posedge clk); n++; end
      chk("a_done_in_time", 32'(q_a.size()), 32'd0);
      q_a.delete();
   endtask

   task automatic wait_done_b(input int budget);
      int n = 0;
      while (q_b.size() != 0 && n < budget) begin @(posedge clk); n++; end
      chk("b_done_in_time", 32'(q_b.size()), 32'd0);
      q_b.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int n;
   int nz_before;

   initial begin
      // "Hi" under key 3: ks = rev8(3) = 0xC0
      for (int i = 0; i < 256; i++) begin
         ct_mem[i] = 8'h00; pt_mem_a[i] = 8'h00; pt_mem_b[i] = 8'h00;
      end
      ct_mem[0] = 8'h02;
      ct_mem[1] = 8'h88;
      ct_mem[2] = 8'hA9;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdy",       32'(rdy_a),        32'd1);
      chk("rst_key",       32'(key_a),        32'd0);
      chk("rst_key_valid", 32'(key_valid_a),  32'd0);
      chk("rst_exhausted", 32'(exhausted_a),  32'd0);
      chk("rst_arc4_en",   32'(arc4_en_a),    32'd0);
      chk("rst_arc4_busy", 32'(arc4_busy_a),  32'd0);
      chk("rst_ct_addr",   32'(ct_addr_a),    32'd0);
      chk("rst_pt_addr",   32'(pt_addr_a),    32'd0);
      chk("rst_b_rdy",     32'(rdy_b),        32'd1);
      rst = 1'b0;
      mon_en = 1'b1;

      // Stride-1 sweep finds key 3 after rejecting 0,1,2; a stray en mid-run is ignored
      q_a.push_back('{key:24'h3, valid:1'b1, exh:1'b0, tried:exp_tried(3)});
      start_a(24'h0, 24'hFF);
      repeat (3) @(posedge clk);
      #1; key_start_a = 24'h50; en_a = 1'b1;
      @(posedge clk); #1; en_a = 1'b0;
      wait_done_a(2000);

      // Zero-length message: first key accepted without PT reads
      ct_mem[0] = 8'h00;
      nz_before = pt_nz_cnt;
      q_a.push_back('{key:24'h55, valid:1'b1, exh:1'b0, tried:exp_tried(0)});
      start_a(24'h55, 24'h60);
      wait_done_a(500);
      chk("len0_pt_addr_nonzero_cycles", 32'(pt_nz_cnt - nz_before), 32'd0);
      ct_mem[0] = 8'h02;

      // Stride 4, 8-bit keys
      q_b.push_back('{key:24'h03, valid:1'b1, exh:1'b0, tried:exp_tried(0)});
      start_b(8'h03, 8'hFF);
      wait_done_b(1000);
      q_b.push_back('{key:24'h10, valid:1'b0, exh:1'b1, tried:exp_tried(5)});
      start_b(8'h00, 8'h10);
      wait_done_b(2000);
      q_b.push_back('{key:24'hFE, valid:1'b0, exh:1'b1, tried:exp_tried(1)});
      start_b(8'hFE, 8'hFF);
      wait_done_b(1000);

      // key_start above key_limit: key 5 fails on byte 2, then exhausted
      q_a.push_back('{key:24'h5, valid:1'b0, exh:1'b1, tried:exp_tried(1)});
      start_a(24'h5, 24'h2);
      wait_done_a(1000);

      // Stop during RUN: drain arc4, no result flags
      q_a.push_back('{key:24'h20, valid:1'b0, exh:1'b0, tried:exp_tried(0)});
      start_a(24'h20, 24'hFF);
      n = 0;
      while (!arc4_busy_a && n < 50) begin @(posedge clk); #1; n++; end
      chk("stop_busy_seen", 32'(arc4_busy_a), 32'd1);
      repeat (2) @(posedge clk);
      #1; stop_a = 1'b1;
      @(posedge clk); #1; stop_a = 1'b0;
      chk("drain_busy", 32'(arc4_busy_a), 32'd1);
      chk("drain_rdy",  32'(rdy_a),       32'd0);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!arc4_rdy_a && n < 50);
      chk("drain_arc4_rdy_seen",   32'(arc4_rdy_a), 32'd1);
      chk("drain_rdy_same_cycle",  32'(rdy_a),      32'd0);
      @(posedge clk); #1;
      chk("drain_rdy_next_cycle",  32'(rdy_a),      32'd1);
      wait_done_a(100);

      // Restart after stop uses the new key_start
      q_a.push_back('{key:24'h3, valid:1'b1, exh:1'b0, tried:exp_tried(0)});
      start_a(24'h3, 24'hFF);
      wait_done_a(1000);

      // Reset while checking a byte
      q_a.push_back('{key:24'h0, valid:1'b0, exh:1'b0, tried:exp_tried(0)});
      start_a(24'h0, 24'hFF);
      n = 0;
      while (pt_addr_a != 8'h01 && n < 100) begin @(posedge clk); #1; n++; end
      chk("rst_chk_reached", 32'(pt_addr_a), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rstchk_rdy",       32'(rdy_a),       32'd1);
      chk("rstchk_key",       32'(key_a),       32'd0);
      chk("rstchk_key_valid", 32'(key_valid_a), 32'd0);
      chk("rstchk_exhausted", 32'(exhausted_a), 32'd0);
      chk("rstchk_arc4_en",   32'(arc4_en_a),   32'd0);
      chk("rstchk_arc4_busy", 32'(arc4_busy_a), 32'd0);
      chk("rstchk_pt_addr",   32'(pt_addr_a),   32'd0);
      rst = 1'b0;
      wait_done_a(20);

      repeat (5) @(posedge clk);
      chk("final_q_a_empty", 32'(q_a.size()), 32'd0);
      chk("final_q_b_empty", 32'(q_b.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_crack_search
`default_nettype wire
